gate_sweeper: RTL
=================

# gate_sweeper

Self-checking stimulus engine for small combinational gates. On a start pulse it drives every input vector of an N-input gate under test in ascending order. After a programmable settle delay it samples the gate output and compares it against a truth-table parameter. It then reports pass/fail, an error count and the first failing vector. It sits directly upstream of the gate (drives its inputs) and directly downstream of it (consumes its output), so a two-input gate such as and_gate becomes a clocked, self-checking unit.

## Interface
- N_IN, 2: number of gate inputs; 1..8.
- TRUTH, 4'b1000: expected output per vector, width 2**N_IN; bit k is the expected y when stim == k (default = 2-input AND).
- SETTLE, 1: cycles between applying a vector and sampling dut_y; 1..15.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- stim  out  N_IN  vector driven to the gate; stim[N_IN-1] is the MSB input (for AND: stim = {a,b}).
- dut_y  in  1  gate output under test.
- busy  out  1  high while a sweep is running.
- done  out  1  high from sweep completion until next start or rst.
- pass  out  1  valid while done; 1 iff err_count == 0.
- err_count  out  N_IN+1  mismatches in current/last sweep; max 2**N_IN, so no saturation.
- fail_valid  out  1  at least one mismatch recorded.
- fail_vec  out  N_IN  first mismatching vector; valid when fail_valid.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start: stim<=0, err_count<=0, fail_valid<=0, fail_vec<=0, done<=0, pass<=0, busy<=1, settle counter<=SETTLE-1, go SETTLE.
- SETTLE: counter decrements each cycle; at 0 go CHECK.
- CHECK: compare dut_y to TRUTH[stim] with case inequality. X or Z on dut_y is a mismatch.
  - On mismatch: err_count+1. If fail_valid==0, fail_vec<=stim and fail_valid<=1.
  - If stim != all-ones: stim<=stim+1, counter<=SETTLE-1, go SETTLE.
  - Else go DONE: busy<=0, done<=1, pass<=(final err_count==0), including the last vector's result. stim holds the last vector.
- start in SETTLE/CHECK: ignored; no restart.
- start in DONE: identical to start in IDLE (full clear, new sweep).
- rst at any cycle, including mid-sweep: next state IDLE, all outputs to reset values; the partial sweep is discarded.

## Timing
- Reset values: stim=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0; state IDLE.
- Start sampled at edge E0: stim=0 and busy=1 are visible after E0.
- Each vector is held SETTLE+1 cycles: SETTLE cycles in SETTLE state, 1 in CHECK. dut_y is sampled at the edge that ends the CHECK cycle.
- Vector k is applied after edge E0+k*(SETTLE+1).
- done=1 and busy=0 are visible after edge E0+2**N_IN*(SETTLE+1).
  - Defaults: 8 cycles.
- busy and done are never high together.
- err_count and fail_* update at the edge ending each CHECK cycle.
- No combinational path from dut_y or start to any output.

## Test plan
- Reset: hold rst 2 cycles with start=1 -> all outputs 0, busy stays 0.
- Good AND, defaults, real and_gate instance, 1-cycle start:
  - stim = 0,1,2,3, each held 2 cycles.
  - done rises 8 cycles after the start edge.
  - pass=1, err_count=0, fail_valid=0.
- Stuck-at-0 (dut_y=0), defaults -> err_count=1, fail_vec=3, fail_valid=1, pass=0.
- Stuck-at-1 (dut_y=1), SETTLE=3:
  - err_count=3, fail_vec=0, pass=0.
  - done 16 cycles after start; each vector held 4 cycles.
- dut_y=X throughout -> err_count=4, fail_vec=0, pass=0.
- Control:
  - start pulsed while busy at vector 2 -> sweep unaffected.
  - rst asserted during vector 2 -> all outputs 0 next cycle.
  - New start after rst -> full clean 8-cycle sweep with pass=1.
  - start in DONE -> done drops, counters clear, new sweep runs.

Source files
------------

// File: rtl/gate_sweeper.sv
// Exhaustive sweep engine for a small combinational gate: drives every input vector in order,
// samples the gate output after a settle delay and tallies mismatches against a truth table.
module gate_sweeper #(
    parameter int unsigned          N_IN   = 2,
    parameter logic [2**N_IN-1:0]   TRUTH  = 4'b1000,
    parameter int unsigned          SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StCheck  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [3:0]      SettleLoad = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] StimOne    = N_IN'(1);
    localparam logic [N_IN:0]   ErrOne     = (N_IN + 1)'(1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [N_IN:0]   err_q, err_d;
    logic            fail_valid_q, fail_valid_d;
    logic [N_IN-1:0] fail_vec_q, fail_vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            mismatch;

    // Case inequality so an X or Z from the gate counts as a failure.
    assign mismatch = (dut_y !== TRUTH[stim_q]);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stim_d       = stim_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    stim_d       = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                    cnt_d        = SettleLoad;
                    state_d      = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_d = err_q + ErrOne;
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = stim_q;
                    end
                end
                if (&stim_q) begin
                    // pass must include the verdict on the final vector, hence err_d.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    state_d = StDone;
                end else begin
                    stim_d  = stim_q + StimOne;
                    cnt_d   = SettleLoad;
                    state_d = StSettle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            stim_q       <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stim_q       <= stim_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule
